// File: rtl/onewire_master.sv
// Byte-level 1-wire bus master: bus reset with presence detect, write byte, read byte.
// Defining ONEWIRE_CRC_EN adds a Dallas CRC-8 accumulator over read bits (out_crc, in_crc_clear).
module onewire_master #(
   parameter int MAIN_CLK    = 27_000_000,
   parameter int RESET_US    = 480,
   parameter int PRESENCE_US = 70,
   parameter int SLOT_US     = 60,
   parameter int LOW_US      = 6,
   parameter int SAMPLE_US   = 15,
   parameter int RECOV_US    = 5
) (
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic       in_start,
   input  logic [1:0] in_cmd,
   input  logic [7:0] in_byte,
`ifdef ONEWIRE_CRC_EN
   input  logic       in_crc_clear,
   output logic [7:0] out_crc,
`endif
   output logic       out_ready,
   output logic       out_finished,
   output logic [7:0] out_byte,
   output logic       out_presence,
   inout  wire        inout_dat
);
   localparam int TICK = MAIN_CLK / 1_000_000;
   localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
   localparam int UW   = 10;

   typedef enum logic [2:0] {
      IDLE, RST_LOW, RST_HIGH, SLOT_LOW, SLOT_REL, SLOT_RECOV, DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [UW-1:0]   us_q, us_d;
   logic [2:0]      bit_q, bit_d;
   logic [1:0]      cmd_q, cmd_d;
   logic [7:0]      data_q, data_d;
   logic            rx_q, rx_d;
   logic [7:0]      byte_q, byte_d;
   logic            pres_q, pres_d;
   logic            drive_q, ready_q, fin_q;
   logic [1:0]      sync_q;
   logic [7:0]      crc_q, crc_d;
   logic            tick_s, line_s, wr0_s;
   logic [UW-1:0]   low_end_s;

   // Dallas CRC-8 (reflected 0x8C), one bit, LSB first
   function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
      logic fb;
      fb = crc[0] ^ b;
      return {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
   endfunction

   assign tick_s    = (pre_q == PW'(TICK - 1));
   assign line_s    = sync_q[1];
   assign wr0_s     = (cmd_q == 2'd1) && !data_q[0];
   assign low_end_s = wr0_s ? UW'(SLOT_US - 1) : UW'(LOW_US - 1);

   // Next-state, command datapath and microsecond timebase
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      data_d  = data_q;
      bit_d   = bit_q;
      rx_d    = rx_q;
      byte_d  = byte_q;
      pres_d  = pres_q;
      crc_d   = crc_q;
      case (state_q)
         IDLE: begin
            if (in_start && ready_q) begin
               cmd_d  = in_cmd;
               data_d = in_byte;
               bit_d  = 3'd0;
               case (in_cmd)
                  2'd0: begin
                     state_d = RST_LOW;
                     crc_d   = 8'h00;
                  end
                  2'd1, 2'd2: state_d = SLOT_LOW;
                  default:    state_d = DONE;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         RST_LOW: begin
            if (tick_s && us_q == UW'(RESET_US - 1)) state_d = RST_HIGH;
            else                                     state_d = RST_LOW;
         end
         RST_HIGH: begin
            if (tick_s && us_q == UW'(PRESENCE_US - 1)) pres_d = ~line_s;
            else                                        pres_d = pres_q;
            if (tick_s && us_q == UW'(RESET_US - 1)) state_d = DONE;
            else                                     state_d = RST_HIGH;
         end
         SLOT_LOW: begin
            // A write-0 slot is low for the whole slot, so the released phase is skipped
            if (tick_s && us_q == low_end_s) state_d = wr0_s ? SLOT_RECOV : SLOT_REL;
            else                             state_d = SLOT_LOW;
         end
         SLOT_REL: begin
            if (tick_s && us_q == UW'(SAMPLE_US - LOW_US - 1) && cmd_q == 2'd2) begin
               rx_d  = line_s;
               crc_d = crc8_bit(crc_q, line_s);
            end else begin
               rx_d  = rx_q;
            end
            if (tick_s && us_q == UW'(SLOT_US - LOW_US - 1)) state_d = SLOT_RECOV;
            else                                             state_d = SLOT_REL;
         end
         SLOT_RECOV: begin
            if (tick_s && us_q == UW'(RECOV_US - 1)) begin
               data_d = {rx_q, data_q[7:1]};
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = DONE;
                  if (cmd_q == 2'd2) byte_d = {rx_q, data_q[7:1]};
                  else               byte_d = byte_q;
               end else begin
                  state_d = SLOT_LOW;
               end
            end else begin
               state_d = SLOT_RECOV;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef ONEWIRE_CRC_EN
      if (in_crc_clear) crc_d = 8'h00;
      else              crc_d = crc_d;
`endif
      if (state_d != state_q) begin
         pre_d = '0;
         us_d  = '0;
      end else if (tick_s) begin
         pre_d = '0;
         us_d  = us_q + 10'd1;
      end else begin
         pre_d = pre_q + PW'(1);
         us_d  = us_q;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state_q <= IDLE;
         pre_q   <= '0;
         us_q    <= '0;
         bit_q   <= 3'd0;
         cmd_q   <= 2'd0;
         data_q  <= 8'h00;
         rx_q    <= 1'b0;
         byte_q  <= 8'h00;
         pres_q  <= 1'b0;
         crc_q   <= 8'h00;
         drive_q <= 1'b0;
         ready_q <= 1'b1;
         fin_q   <= 1'b0;
         sync_q  <= 2'b11;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         us_q    <= us_d;
         bit_q   <= bit_d;
         cmd_q   <= cmd_d;
         data_q  <= data_d;
         rx_q    <= rx_d;
         byte_q  <= byte_d;
         pres_q  <= pres_d;
         crc_q   <= crc_d;
         drive_q <= (state_d == RST_LOW) || (state_d == SLOT_LOW);
         ready_q <= (state_d == IDLE);
         fin_q   <= (state_d == DONE);
         sync_q  <= {sync_q[0], inout_dat};
      end
   end

   assign inout_dat    = drive_q ? 1'b0 : 1'bz;
   assign out_ready    = ready_q;
   assign out_finished = fin_q;
   assign out_byte     = byte_q;
   assign out_presence = pres_q;
`ifdef ONEWIRE_CRC_EN
   assign out_crc      = crc_q;
`endif
endmodule

// File: tb/tb_onewire_master.sv
// Directed self-checking bench for onewire_master with a pulled-up bus and a simple device model.
module tb_onewire_master;
`ifdef ONEWIRE_CRC_EN
   localparam int CLK_HZ = 2_000_000;
`else
   localparam int CLK_HZ = 27_000_000;
`endif
   localparam int TU       = CLK_HZ / 1_000_000;
   localparam int LAT_RST  = 1 + 960 * TU;
   localparam int LAT_BYTE = 1 + 8 * 65 * TU;

   logic       clk = 1'b0;
   logic       rst_n, start, dev_low;
   logic [1:0] cmd;
   logic [7:0] wbyte;
   wire        ready, fin, pres;
   wire  [7:0] rbyte;
   wire        dat;
`ifdef ONEWIRE_CRC_EN
   logic       crc_clear;
   wire  [7:0] crc;
   logic [7:0] sp [9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0, fin_cnt = 0, low_run = 0;
   int lows[$];
   int falls[$];
   logic prev_dat = 1'b1;
   int lat, f0;

   always #5 clk = ~clk;

   pullup (dat);
   assign dat = dev_low ? 1'b0 : 1'bz;

   onewire_master #(.MAIN_CLK(CLK_HZ)) dut (
      .in_clk(clk), .in_rst(rst_n), .in_start(start), .in_cmd(cmd), .in_byte(wbyte),
`ifdef ONEWIRE_CRC_EN
      .in_crc_clear(crc_clear), .out_crc(crc),
`endif
      .out_ready(ready), .out_finished(fin), .out_byte(rbyte), .out_presence(pres),
      .inout_dat(dat)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor: low-pulse lengths, falling-edge times, finished pulses
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (fin === 1'b1) fin_cnt++;
         if (dat === 1'b0) begin
            if (prev_dat !== 1'b0) falls.push_back(cyc);
            low_run++;
         end else if (low_run != 0) begin
            lows.push_back(low_run);
            low_run = 0;
         end
         prev_dat = dat;
      end
   end

   task automatic wait_level(input logic lvl, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (dat === lvl) ok = 1'b1;
      end
   endtask

   task automatic run_cmd(input logic [1:0] c, input logic [7:0] b, output int n);
      @(negedge clk);
      cmd = c; wbyte = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (fin !== 1'b1 && n < 30000) begin
         @(negedge clk);
         n++;
      end
      check_eq("busy_in_done", ready, 1'b0);
      @(negedge clk);
      check_eq("fin_one_cycle", fin, 1'b0);
      check_eq("ready_after", ready, 1'b1);
   endtask

   task automatic dev_presence();
      bit ok;
      wait_level(1'b0, 100, ok);
      check_eq("pres_dev_saw_reset", ok, 1'b1);
      wait_level(1'b1, 600 * TU, ok);
      check_eq("pres_dev_saw_release", ok, 1'b1);
      repeat (30 * TU) @(negedge clk);
      dev_low = 1'b1;
      repeat (120 * TU) @(negedge clk);
      dev_low = 1'b0;
   endtask

   task automatic dev_read(input logic [7:0] v);
      bit ok;
      for (int i = 0; i < 8; i++) begin
         wait_level(1'b0, 100 * TU, ok);
         if (!ok) check_eq("rd_dev_slot", ok, 1'b1);
         if (!v[i]) dev_low = 1'b1;
         repeat (29 * TU) @(negedge clk);
         dev_low = 1'b0;
      end
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0; start = 1'b0; cmd = 2'd0; wbyte = 8'h00; dev_low = 1'b0;
`ifdef ONEWIRE_CRC_EN
      crc_clear = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_eq("rst_ready", ready, 1'b1);
      check_eq("rst_fin", fin, 1'b0);
      check_eq("rst_byte", rbyte, 8'h00);
      check_eq("rst_pres", pres, 1'b0);
      check_eq("rst_line", dat, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      lows.delete();
      fork
         run_cmd(2'd0, 8'h00, lat);
         dev_presence();
      join
      check_eq("pres_latency", lat, LAT_RST);
      check_eq("pres_flag", pres, 1'b1);
      check_eq("pres_low_len", (lows.size() > 0) ? lows[0] : -1, 480 * TU);

      // Abort a write of 0x00 halfway through the 4th slot
      falls.delete();
      @(negedge clk);
      cmd = 2'd1; wbyte = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 400 * TU && !ok; i++) begin
         @(negedge clk);
         if (falls.size() >= 4) ok = 1'b1;
      end
      check_eq("abort_slot4_seen", ok, 1'b1);
      repeat (30 * TU) @(negedge clk);
      check_eq("abort_pre_low", dat, 1'b0);
      f0 = fin_cnt;
      rst_n = 1'b0;
      #1;
      check_eq("abort_release", dat, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("abort_no_fin", fin_cnt, f0);
      check_eq("abort_ready", ready, 1'b1);
      check_eq("abort_pres_clr", pres, 1'b0);

      fork
         run_cmd(2'd2, 8'h00, lat);
         dev_read(8'hA5);
      join
      check_eq("read_latency", lat, LAT_BYTE);
      check_eq("read_byte", rbyte, 8'hA5);

      lows.delete();
      run_cmd(2'd0, 8'h00, lat);
      check_eq("nodev_latency", lat, LAT_RST);
      check_eq("nodev_pres", pres, 1'b0);
      check_eq("nodev_pulses", lows.size(), 1);
      check_eq("nodev_low_len", (lows.size() > 0) ? lows[0] : -1, 480 * TU);

      // Write 0xCC with a stray start pulse while busy
      lows.delete(); falls.delete();
      f0 = fin_cnt;
      wbyte = 8'hCC;
      fork
         run_cmd(2'd1, 8'hCC, lat);
         begin
            repeat (40 * TU) @(negedge clk);
            cmd = 2'd0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      check_eq("write_latency", lat, LAT_BYTE);
      check_eq("write_fin_count", fin_cnt - f0, 1);
      check_eq("write_slots", lows.size(), 8);
      for (int i = 0; i < 8; i++)
         check_eq($sformatf("write_low%0d", i), (i < lows.size()) ? lows[i] : -1,
                  ((8'hCC >> i) & 1) ? 6 * TU : 60 * TU);
      check_eq("write_period_a", (falls.size() > 1) ? falls[1] - falls[0] : -1, 65 * TU);
      check_eq("write_period_b", (falls.size() > 7) ? falls[7] - falls[6] : -1, 65 * TU);
      check_eq("write_byte_held", rbyte, 8'hA5);

      lows.delete();
      run_cmd(2'd3, 8'h00, lat);
      check_eq("noop_latency", lat, 1);
      check_eq("noop_no_bus", lows.size(), 0);

`ifdef ONEWIRE_CRC_EN
      @(negedge clk); crc_clear = 1'b1;
      @(negedge clk); crc_clear = 1'b0;
      check_eq("crc_cleared", crc, 8'h00);
      for (int k = 0; k < 9; k++) begin
         fork
            run_cmd(2'd2, 8'h00, lat);
            dev_read(sp[k]);
         join
      end
      check_eq("crc_last_byte", rbyte, 8'h1C);
      check_eq("crc_good", crc, 8'h00);
      @(negedge clk); crc_clear = 1'b1;
      @(negedge clk); crc_clear = 1'b0;
      for (int k = 0; k < 9; k++) begin
         fork
            run_cmd(2'd2, 8'h00, lat);
            dev_read((k == 2) ? (sp[k] ^ 8'h01) : sp[k]);
         join
      end
      check_eq("crc_bad_nonzero", (crc != 8'h00), 1'b1);
`endif

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("final_rst_byte", rbyte, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
